// File: rtl/note_pkg.sv
// ============================================================================
// Module   : note_pkg
// Brief    : Pitch/octave codes, ASCII constants and note-decoding helpers
//            shared by the note generator's UART and display paths.
// Revision : 1.0
// ============================================================================
`default_nettype none

package note_pkg;

  localparam logic [3:0] PITCH_C  = 4'd0;
  localparam logic [3:0] PITCH_CS = 4'd1;
  localparam logic [3:0] PITCH_D  = 4'd2;
  localparam logic [3:0] PITCH_DS = 4'd3;
  localparam logic [3:0] PITCH_E  = 4'd4;
  localparam logic [3:0] PITCH_F  = 4'd5;
  localparam logic [3:0] PITCH_FS = 4'd6;
  localparam logic [3:0] PITCH_G  = 4'd7;
  localparam logic [3:0] PITCH_GS = 4'd8;
  localparam logic [3:0] PITCH_A  = 4'd9;
  localparam logic [3:0] PITCH_AS = 4'd10;
  localparam logic [3:0] PITCH_B  = 4'd11;

  localparam logic [1:0] OCT_3 = 2'd0;
  localparam logic [1:0] OCT_4 = 2'd1;
  localparam logic [1:0] OCT_5 = 2'd2;
  localparam logic [1:0] OCT_6 = 2'd3;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_SHARP = 8'h23;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_FLAT  = 8'h62;
  localparam logic [7:0] ASCII_3     = 8'h33;
  localparam logic [7:0] ASCII_6     = 8'h36;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_G     = 8'h47;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    P_NOTE = 3'd0,
    P_ACC  = 3'd1,
    P_OCT  = 3'd2,
    P_TAIL = 3'd3,
    P_SKIP = 3'd4
  } parse_state_t;

  function automatic logic [3:0] letter_to_pitch(input logic [7:0] ch);
    case (ch)
      8'h41:   return PITCH_A;
      8'h42:   return PITCH_B;
      8'h43:   return PITCH_C;
      8'h44:   return PITCH_D;
      8'h45:   return PITCH_E;
      8'h46:   return PITCH_F;
      8'h47:   return PITCH_G;
      default: return PITCH_C;
    endcase
  endfunction

  function automatic logic is_letter(input logic [7:0] ch);
    return (ch >= ASCII_A) && (ch <= ASCII_G);
  endfunction

  function automatic logic is_octave_digit(input logic [7:0] ch);
    return (ch >= ASCII_3) && (ch <= ASCII_6);
  endfunction

  function automatic logic [1:0] digit_to_octave(input logic [7:0] ch);
    logic [7:0] d;
    d = ch - ASCII_3;
    return d[1:0];
  endfunction

  function automatic logic is_eol(input logic [7:0] ch);
    return (ch == ASCII_CR) || (ch == ASCII_LF);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// Module   : uart_rx_core
// Brief    : 8N1 UART receiver with input synchronizer and mid-bit sampling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_core
  import note_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  rx_state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [2:0]             r_bit, w_bit_nxt;
  logic [7:0]             r_shift, w_shift_nxt;
  logic                   r_armed, w_armed_nxt;
  logic                   w_load, w_ferr, w_rx;
  logic [7:0]             r_byte;
  logic                   r_byte_valid, r_frame_err;

  assign w_rx = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync       <= '1;
      r_state      <= R_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_armed      <= 1'b1;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit        <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_armed      <= w_armed_nxt;
      r_byte_valid <= w_load;
      r_frame_err  <= w_ferr;
      if (w_load) r_byte <= r_shift;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    // After a framing error the line may still be low; wait for idle before re-arming.
    w_armed_nxt = r_armed | w_rx;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    if (!i_enable) begin
      w_state_nxt = R_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          w_cnt_nxt = '0;
          w_bit_nxt = '0;
          if (r_armed && !w_rx) w_state_nxt = R_START;
        end
        R_START: begin
          if (r_cnt == c_HALF) begin
            w_cnt_nxt   = '0;
            w_state_nxt = w_rx ? R_IDLE : R_DATA;
          end
        end
        R_DATA: begin
          if (r_cnt == c_LAST) begin
            w_cnt_nxt   = '0;
            w_shift_nxt = {w_rx, r_shift[7:1]};
            w_bit_nxt   = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_nxt = R_STOP;
          end
        end
        R_STOP: begin
          if (r_cnt == c_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = R_IDLE;
            if (w_rx) begin
              w_load = 1'b1;
            end else begin
              w_ferr      = 1'b1;
              w_armed_nxt = 1'b0;
            end
          end
        end
        default: w_state_nxt = R_IDLE;
      endcase
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = (r_state != R_IDLE);

endmodule

`default_nettype wire

// File: rtl/uart_note_rx.sv
// ============================================================================
// Module   : uart_note_rx
// Brief    : UART receiver plus ASCII note-line parser ("C#4\r\n" -> pitch/octave).
//            Optional macro NOTE_RX_FLATS_EN accepts 'b' flats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_note_rx
  import note_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 115200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx_enable,
  input  logic       i_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_byte_valid,
  output logic       o_frame_err,
  output logic       o_parse_err,
  output logic [3:0] o_note_pitch,
  output logic [1:0] o_note_octave,
  output logic       o_note_valid,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  logic [7:0]   w_byte;
  logic         w_bv, w_ferr;
  parse_state_t r_pstate, w_pstate_nxt;
  logic [3:0]   r_base, w_base_nxt;
  logic [1:0]   r_oct, w_oct_nxt;
  logic         r_pend, w_pend_nxt;
  logic         w_commit, w_perr;
  logic [3:0]   r_pitch;
  logic [1:0]   r_octave;
  logic         r_note_valid, r_parse_err;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (i_rx_enable),
    .i_rx         (i_rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_bv),
    .o_frame_err  (w_ferr),
    .o_busy       (o_busy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pstate     <= P_NOTE;
      r_base       <= PITCH_A;
      r_oct        <= OCT_4;
      r_pend       <= 1'b0;
      r_pitch      <= PITCH_A;
      r_octave     <= OCT_4;
      r_note_valid <= 1'b0;
      r_parse_err  <= 1'b0;
    end else begin
      r_pstate     <= w_pstate_nxt;
      r_base       <= w_base_nxt;
      r_oct        <= w_oct_nxt;
      r_pend       <= w_pend_nxt;
      r_note_valid <= w_commit;
      r_parse_err  <= w_perr;
      if (w_commit) begin
        r_pitch  <= r_base;
        r_octave <= r_oct;
      end
    end
  end

  always_comb begin
    w_pstate_nxt = r_pstate;
    w_base_nxt   = r_base;
    w_oct_nxt    = r_oct;
    w_pend_nxt   = r_pend;
    w_commit     = 1'b0;
    w_perr       = 1'b0;
    if (!i_rx_enable) begin
      w_pstate_nxt = P_NOTE;
      w_pend_nxt   = 1'b0;
    end else if (w_ferr) begin
      // A corrupted byte at line start loses nothing; mid-line it poisons the line.
      if (r_pstate != P_NOTE) w_pstate_nxt = P_SKIP;
      w_pend_nxt = 1'b0;
    end else if (w_bv) begin
      case (r_pstate)
        P_NOTE: begin
          if (is_letter(w_byte)) begin
            w_base_nxt   = letter_to_pitch(w_byte);
            w_pstate_nxt = P_ACC;
          end else if (!is_eol(w_byte)) begin
            w_perr       = 1'b1;
            w_pstate_nxt = P_SKIP;
          end
        end
        P_ACC: begin
          if (w_byte == ASCII_SHARP) begin
            if (r_base == PITCH_E || r_base == PITCH_B) begin
              w_perr       = 1'b1;
              w_pstate_nxt = P_SKIP;
            end else begin
              w_base_nxt   = r_base + 4'd1;
              w_pstate_nxt = P_OCT;
            end
          end else if (w_byte == ASCII_SPACE) begin
            w_pstate_nxt = P_OCT;
          end else if (is_octave_digit(w_byte)) begin
            w_oct_nxt    = digit_to_octave(w_byte);
            w_pstate_nxt = P_TAIL;
`ifdef NOTE_RX_FLATS_EN
          end else if (w_byte == ASCII_FLAT) begin
            if (r_base == PITCH_C || r_base == PITCH_F) begin
              w_perr       = 1'b1;
              w_pstate_nxt = P_SKIP;
            end else begin
              w_base_nxt   = r_base - 4'd1;
              w_pstate_nxt = P_OCT;
            end
`endif
          end else begin
            w_perr       = 1'b1;
            w_pstate_nxt = P_SKIP;
          end
        end
        P_OCT: begin
          if (is_octave_digit(w_byte)) begin
            w_oct_nxt    = digit_to_octave(w_byte);
            w_pstate_nxt = P_TAIL;
          end else begin
            w_perr       = 1'b1;
            w_pstate_nxt = P_SKIP;
          end
        end
        P_TAIL: begin
          if (is_eol(w_byte)) begin
            w_commit     = 1'b1;
            w_pstate_nxt = P_NOTE;
          end else if (w_byte == ASCII_COMMA) begin
            w_pend_nxt   = 1'b1;
            w_pstate_nxt = P_SKIP;
          end else begin
            w_perr       = 1'b1;
            w_pend_nxt   = 1'b0;
            w_pstate_nxt = P_SKIP;
          end
        end
        P_SKIP: begin
          if (is_eol(w_byte)) begin
            w_commit     = r_pend;
            w_pend_nxt   = 1'b0;
            w_pstate_nxt = P_NOTE;
          end
        end
        default: w_pstate_nxt = P_NOTE;
      endcase
    end
  end

  assign o_rx_byte       = w_byte;
  assign o_rx_byte_valid = w_bv;
  assign o_frame_err     = w_ferr;
  assign o_parse_err     = r_parse_err;
  assign o_note_pitch    = r_pitch;
  assign o_note_octave   = r_octave;
  assign o_note_valid    = r_note_valid;

endmodule

`default_nettype wire

// File: tb/tb_uart_note_rx.sv
// ============================================================================
// Module   : tb_uart_note_rx
// Brief    : Directed self-checking bench for uart_note_rx (50 clocks per bit).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_note_rx;

  localparam int CPB = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_rx_enable = 1'b1;
  logic       i_rx = 1'b1;
  logic [7:0] o_rx_byte;
  logic       o_rx_byte_valid, o_frame_err, o_parse_err, o_note_valid, o_busy;
  logic [3:0] o_note_pitch;
  logic [1:0] o_note_octave;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_nv = 0, cnt_perr = 0, cnt_ferr = 0, cnt_bv = 0, cnt_both = 0;
  int b_nv, b_perr, b_ferr, b_bv;

  always #5 clk = ~clk;

  uart_note_rx #(
    .CLK_HZ      (50000000),
    .BAUD        (1000000),
    .SYNC_STAGES (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_rx_enable     (i_rx_enable),
    .i_rx            (i_rx),
    .o_rx_byte       (o_rx_byte),
    .o_rx_byte_valid (o_rx_byte_valid),
    .o_frame_err     (o_frame_err),
    .o_parse_err     (o_parse_err),
    .o_note_pitch    (o_note_pitch),
    .o_note_octave   (o_note_octave),
    .o_note_valid    (o_note_valid),
    .o_busy          (o_busy)
  );

  always @(posedge clk) begin
    if (o_note_valid)    cnt_nv   <= cnt_nv + 1;
    if (o_parse_err)     cnt_perr <= cnt_perr + 1;
    if (o_frame_err)     cnt_ferr <= cnt_ferr + 1;
    if (o_rx_byte_valid) cnt_bv   <= cnt_bv + 1;
    if (o_note_valid && o_parse_err) cnt_both <= cnt_both + 1;
  end

  task automatic snap();
    b_nv = cnt_nv; b_perr = cnt_perr; b_ferr = cnt_ferr; b_bv = cnt_bv;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    i_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    i_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (o_note_pitch !== 4'd9) begin n_bad++; $display("FAIL reset_pitch got %0d want 9", o_note_pitch); end
    if (o_note_octave !== 2'd1) begin n_bad++; $display("FAIL reset_octave got %0d want 1", o_note_octave); end
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
    if (o_rx_byte !== 8'h00) begin n_bad++; $display("FAIL reset_byte got %h want 00", o_rx_byte); end
    if (o_note_valid !== 1'b0 || o_parse_err !== 1'b0 || o_frame_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses got nv=%b pe=%b fe=%b want 0", o_note_valid, o_parse_err, o_frame_err);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_parse_err();
    snap();
    send_str("E#5\n");
    n_cmp += 4;
    if (cnt_perr - b_perr != 1) begin n_bad++; $display("FAIL esharp_perr got %0d want 1", cnt_perr - b_perr); end
    if (cnt_nv - b_nv != 0) begin n_bad++; $display("FAIL esharp_nv got %0d want 0", cnt_nv - b_nv); end
    if (o_note_pitch !== 4'd9) begin n_bad++; $display("FAIL esharp_pitch got %0d want 9", o_note_pitch); end
    if (o_note_octave !== 2'd1) begin n_bad++; $display("FAIL esharp_oct got %0d want 1", o_note_octave); end
    snap();
    send_str("G 3\n");
    n_cmp += 3;
    if (cnt_nv - b_nv != 1) begin n_bad++; $display("FAIL g3_nv got %0d want 1", cnt_nv - b_nv); end
    if (o_note_pitch !== 4'd7) begin n_bad++; $display("FAIL g3_pitch got %0d want 7", o_note_pitch); end
    if (o_note_octave !== 2'd0) begin n_bad++; $display("FAIL g3_oct got %0d want 0", o_note_octave); end
  endtask

  task automatic test_sharp();
    snap();
    send_str("C#4\r\n");
    n_cmp += 6;
    if (cnt_nv - b_nv != 1) begin n_bad++; $display("FAIL c4_nv got %0d want 1", cnt_nv - b_nv); end
    if (o_note_pitch !== 4'd1) begin n_bad++; $display("FAIL c4_pitch got %0d want 1", o_note_pitch); end
    if (o_note_octave !== 2'd1) begin n_bad++; $display("FAIL c4_oct got %0d want 1", o_note_octave); end
    if (cnt_perr - b_perr != 0) begin n_bad++; $display("FAIL c4_perr got %0d want 0", cnt_perr - b_perr); end
    if (cnt_bv - b_bv != 5) begin n_bad++; $display("FAIL c4_bytes got %0d want 5", cnt_bv - b_bv); end
    if (o_rx_byte !== 8'h0A) begin n_bad++; $display("FAIL c4_lastbyte got %h want 0a", o_rx_byte); end
  endtask

  task automatic test_status_line();
    snap();
    send_str("A#6,1865,1864\r\n");
    n_cmp += 4;
    if (cnt_nv - b_nv != 1) begin n_bad++; $display("FAIL status_nv got %0d want 1", cnt_nv - b_nv); end
    if (o_note_pitch !== 4'd10) begin n_bad++; $display("FAIL status_pitch got %0d want 10", o_note_pitch); end
    if (o_note_octave !== 2'd3) begin n_bad++; $display("FAIL status_oct got %0d want 3", o_note_octave); end
    if (cnt_perr - b_perr != 0) begin n_bad++; $display("FAIL status_perr got %0d want 0", cnt_perr - b_perr); end
  endtask

  task automatic test_frame_err();
    snap();
    send_byte(8'h44, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    n_cmp += 3;
    if (cnt_ferr - b_ferr != 1) begin n_bad++; $display("FAIL ferr_count got %0d want 1", cnt_ferr - b_ferr); end
    if (cnt_bv - b_bv != 0) begin n_bad++; $display("FAIL ferr_bv got %0d want 0", cnt_bv - b_bv); end
    if (cnt_perr - b_perr != 0) begin n_bad++; $display("FAIL ferr_perr got %0d want 0", cnt_perr - b_perr); end
    snap();
    send_str("D4\n");
    n_cmp += 3;
    if (cnt_nv - b_nv != 1) begin n_bad++; $display("FAIL d4_nv got %0d want 1", cnt_nv - b_nv); end
    if (o_note_pitch !== 4'd2) begin n_bad++; $display("FAIL d4_pitch got %0d want 2", o_note_pitch); end
    if (o_note_octave !== 2'd1) begin n_bad++; $display("FAIL d4_oct got %0d want 1", o_note_octave); end
  endtask

  task automatic test_glitch();
    snap();
    i_rx = 1'b0;
    repeat (20) @(negedge clk);
    i_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_cmp += 2;
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy got %b want 0", o_busy); end
    if ((cnt_bv - b_bv) + (cnt_ferr - b_ferr) + (cnt_perr - b_perr) + (cnt_nv - b_nv) != 0) begin
      n_bad++; $display("FAIL glitch_pulses got %0d want 0",
                        (cnt_bv - b_bv) + (cnt_ferr - b_ferr) + (cnt_perr - b_perr) + (cnt_nv - b_nv));
    end
  endtask

  task automatic test_enable_abort();
    snap();
    i_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    n_cmp += 1;
    if (o_busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before got %b want 1", o_busy); end
    i_rx_enable = 1'b0;
    @(negedge clk);
    n_cmp += 1;
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_after got %b want 0", o_busy); end
    i_rx = 1'b1;
    repeat (8 * CPB) @(negedge clk);
    i_rx_enable = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_cmp += 2;
    if (cnt_bv - b_bv != 0) begin n_bad++; $display("FAIL abort_bv got %0d want 0", cnt_bv - b_bv); end
    if (o_note_pitch !== 4'd2 || o_note_octave !== 2'd1) begin
      n_bad++; $display("FAIL abort_hold got %0d/%0d want 2/1", o_note_pitch, o_note_octave);
    end
  endtask

  task automatic test_flats();
    snap();
    send_str("Bb5\n");
`ifdef NOTE_RX_FLATS_EN
    n_cmp += 3;
    if (cnt_nv - b_nv != 1) begin n_bad++; $display("FAIL bb5_nv got %0d want 1", cnt_nv - b_nv); end
    if (o_note_pitch !== 4'd10) begin n_bad++; $display("FAIL bb5_pitch got %0d want 10", o_note_pitch); end
    if (o_note_octave !== 2'd2) begin n_bad++; $display("FAIL bb5_oct got %0d want 2", o_note_octave); end
    snap();
    send_str("Cb4\n");
    n_cmp += 2;
    if (cnt_perr - b_perr != 1) begin n_bad++; $display("FAIL cb4_perr got %0d want 1", cnt_perr - b_perr); end
    if (o_note_pitch !== 4'd10) begin n_bad++; $display("FAIL cb4_pitch got %0d want 10", o_note_pitch); end
`else
    n_cmp += 3;
    if (cnt_perr - b_perr != 1) begin n_bad++; $display("FAIL bb5_perr got %0d want 1", cnt_perr - b_perr); end
    if (cnt_nv - b_nv != 0) begin n_bad++; $display("FAIL bb5_nv got %0d want 0", cnt_nv - b_nv); end
    if (o_note_pitch !== 4'd2) begin n_bad++; $display("FAIL bb5_pitch got %0d want 2", o_note_pitch); end
`endif
    n_cmp += 1;
    if (cnt_both != 0) begin n_bad++; $display("FAIL nv_perr_overlap got %0d want 0", cnt_both); end
  endtask

  initial begin
    test_reset();
    test_parse_err();
    test_sharp();
    test_status_line();
    test_frame_err();
    test_glitch();
    test_enable_abort();
    test_flats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
